// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer and its bench.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned PC_STEP = 4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; flush overrides push/pop in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(do_push && full && !do_pop));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: issues credit-limited word requests, queues returned words
// with their PCs, and flushes/discards stale traffic on a redirect.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned      size            = 32,
    parameter logic [size-1:0]  RESET_PC        = '0,
    parameter int unsigned      QDEPTH          = 4,
    parameter int unsigned      MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            buble,
    input  logic            misprediction,
    input  logic [size-1:0] correct_pc,
    input  logic            jump,
    input  logic [size-1:0] jump_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [size-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [size-1:0] imem_rsp_data,
    output logic            inst_valid_o,
    output logic [size-1:0] instruction_o,
    output logic [size-1:0] current_pc
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned QW = $clog2(QDEPTH + 1);

    logic [size-1:0]   fetch_pc;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     outstanding_next;
    logic [OW-1:0]     discard;
    logic              q_full;
    logic              q_empty;
    logic [QW-1:0]     q_count;
    logic [2*size-1:0] q_rdata;
    logic              pf_full;
    logic              pf_empty;
    logic [size-1:0]   pf_rdata;
    logic              dequeue;
    logic              take_jump;
    logic              redirect;
    logic              accept;
    logic              q_push;
    logic [QW:0]       in_use;

    assign inst_valid_o  = !q_empty;
    assign instruction_o = q_empty ? '0 : q_rdata[2*size-1:size];
    assign current_pc    = q_empty ? '0 : q_rdata[size-1:0];

    assign dequeue   = inst_valid_o && !buble;
    assign take_jump = jump && dequeue && !misprediction;
    assign redirect  = misprediction || take_jump;

    // Queued words plus words still owed may never exceed the queue, so a
    // response always has a slot and memory needs no backpressure.
    assign in_use = (QW + 1)'(q_count) + (QW + 1)'(outstanding);
    assign imem_req_valid = reset && !redirect && !pf_full && (in_use < (QW + 1)'(QDEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign outstanding_next = outstanding + OW'(accept) - OW'(imem_rsp_valid);
    assign q_push           = imem_rsp_valid && (discard == '0) && !redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            discard  <= '0;
        end else if (redirect) begin
            fetch_pc <= misprediction ? correct_pc : jump_target;
            discard  <= outstanding_next;
        end else begin
            if (accept) fetch_pc <= fetch_pc + size'(PC_STEP);
            if (imem_rsp_valid && (discard != '0)) discard <= discard - 1'b1;
        end
    end

    // In-flight PCs are never flushed; discarded responses still pop them.
    sync_fifo #(.WIDTH(size), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (accept),
        .pop   (imem_rsp_valid),
        .flush (1'b0),
        .wdata (fetch_pc),
        .rdata (pf_rdata),
        .full  (pf_full),
        .empty (pf_empty),
        .count (outstanding)
    );

    sync_fifo #(.WIDTH(2 * size), .DEPTH(QDEPTH)) u_inst_queue (
        .clk   (clk),
        .rst_n (reset),
        .push  (q_push),
        .pop   (dequeue),
        .flush (redirect),
        .wdata ({imem_rsp_data, pf_rdata}),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assert property (@(posedge clk) disable iff (!reset) !(q_push && q_full && !dequeue));
    assert property (@(posedge clk) disable iff (!reset) !(imem_rsp_valid && pf_empty));
    assert property (@(posedge clk) disable iff (!reset) discard <= outstanding);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: queue-based reference model plus directed pins.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int QDEPTH = 4;
    localparam int MAXO   = 2;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        buble;
    logic        misprediction;
    logic [31:0] correct_pc;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid_o;
    logic [31:0] instruction_o;
    logic [31:0] current_pc;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .size(32), .RESET_PC(32'h0), .QDEPTH(QDEPTH), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .buble          (buble),
        .misprediction  (misprediction),
        .correct_pc     (correct_pc),
        .jump           (jump),
        .jump_target    (jump_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid_o   (inst_valid_o),
        .instruction_o  (instruction_o),
        .current_pc     (current_pc)
    );

    // reference model state
    fetch_entry_t mq[$];
    logic [31:0]  infl[$];
    mem_req_t     memq[$];
    int           disc;
    logic [31:0]  mpc;
    int           cyc = 0;

    // stimulus controls
    int          lat = 1;
    bit          ready_rand = 0;
    bit          rand_mode = 0;
    bit          buble_hold = 0;
    bit          jump_arm = 0;
    bit          mis_arm = 0;
    bit          both_arm = 0;
    logic [31:0] jump_on;
    logic [31:0] jump_tgt;
    bit          fired;
    int          fire_idx;
    bit          look_addr;
    bit          got_addr;
    logic [31:0] first_addr;
    int          hs;
    logic [31:0] dlv[$];
    bit          prev_hold;
    logic [31:0] prev_addr;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0101_0101) ^ NOP_INSTR;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_dlv(input string name, input int idx, input logic [31:0] exp);
        if (idx >= 0 && idx < dlv.size()) chk(name, dlv[idx], exp);
        else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no delivery at index %0d, expected pc %h", name, idx, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        infl.delete();
        memq.delete();
        disc = 0;
        mpc = 32'h0;
        prev_hold = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"},  32'(imem_req_valid), 32'h0);
        chk({tag, "_req_addr"},   imem_req_addr, 32'h0);
        chk({tag, "_inst_valid"}, 32'(inst_valid_o), 32'h0);
        chk({tag, "_instruction"}, instruction_o, 32'h0);
        chk({tag, "_current_pc"}, current_pc, 32'h0);
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic step();
        bit          b, m, j, rdy, rv, exp_iv, deq, tj, redir, ev;
        logic [31:0] cpc, jt, rd, p, exp_ins, exp_pc;

        rv = 0;
        rd = 32'h0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            rv = 1;
            rd = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end

        b = buble_hold; m = 0; j = 0; cpc = 32'h0; jt = 32'h0; rdy = 1;
        if (rand_mode) begin
            b   = ($urandom_range(0, 2) == 0);
            m   = ($urandom_range(0, 19) == 0);
            j   = ($urandom_range(0, 5) == 0);
            cpc = $urandom_range(0, 255) << 2;
            jt  = $urandom_range(0, 255) << 2;
        end
        if (ready_rand) rdy = ($urandom_range(0, 1) == 1);
        if (jump_arm && mq.size() > 0 && mq[0].pc == jump_on && !b) begin
            j = 1; jt = jump_tgt; jump_arm = 0; fired = 1; fire_idx = dlv.size();
        end
        if (mis_arm && infl.size() == 2 && !rv) begin
            m = 1; cpc = 32'h100; mis_arm = 0; fired = 1; fire_idx = dlv.size();
        end
        if (both_arm && mq.size() > 0 && !b) begin
            m = 1; cpc = 32'h200; j = 1; jt = 32'h40;
            both_arm = 0; fired = 1; fire_idx = dlv.size(); look_addr = 1;
        end

        buble = b; misprediction = m; correct_pc = cpc; jump = j; jump_target = jt;
        imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd;
        #1;

        exp_iv  = (mq.size() > 0);
        exp_ins = exp_iv ? mq[0].instr : 32'h0;
        exp_pc  = exp_iv ? mq[0].pc : 32'h0;
        deq     = exp_iv && !b;
        tj      = j && deq && !m;
        redir   = m || tj;
        ev      = !redir && (infl.size() < MAXO) && ((mq.size() + infl.size()) < QDEPTH);

        chk("req_valid",   32'(imem_req_valid), 32'(ev));
        chk("req_addr",    imem_req_addr, mpc);
        chk("inst_valid",  32'(inst_valid_o), 32'(exp_iv));
        chk("instruction", instruction_o, exp_ins);
        chk("current_pc",  current_pc, exp_pc);
        if (prev_hold && !redir) chk("addr_stable", imem_req_addr, prev_addr);
        prev_hold = imem_req_valid && !rdy;
        prev_addr = imem_req_addr;

        if (inst_valid_o && !b && !m) dlv.push_back(current_pc);
        if (imem_req_valid && rdy) hs++;
        if (look_addr && !got_addr && imem_req_valid) begin
            got_addr = 1;
            first_addr = imem_req_addr;
        end

        if (rv) begin
            p = (infl.size() > 0) ? infl.pop_front() : 32'h0;
            if (disc > 0) disc--;
            else if (!redir) mq.push_back('{instr: rd, pc: p});
        end
        if (redir) begin
            mq.delete();
            disc = infl.size();
            mpc = m ? cpc : jt;
        end else begin
            if (deq) void'(mq.pop_front());
            if (ev && rdy) begin
                infl.push_back(mpc);
                memq.push_back('{addr: mpc, due: cyc + lat});
                mpc = mpc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        imem_rsp_valid = 0;
        misprediction = 0;
        jump = 0;
        #2;
        reset = 0;
        #1;
        chk_reset_outputs(tag);
        repeat (2) @(negedge clk);
        model_reset();
        dlv.delete();
        fired = 0;
        reset = 1;
    endtask

    initial begin
        int cnt;
        reset = 0; buble = 0; misprediction = 0; correct_pc = 0; jump = 0;
        jump_target = 0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        model_reset();
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        reset = 1;

        // streaming, one-cycle memory
        lat = 1;
        repeat (12) step();
        chk_dlv("stream_pc0", 0, 32'h0);
        chk_dlv("stream_pc1", 1, 32'h4);
        chk_dlv("stream_pc2", 2, 32'h8);

        // stall: credits stop issue at QDEPTH requests
        do_reset("rst_bubble");
        buble_hold = 1;
        hs = 0;
        repeat (10) step();
        chk("bubble_issue_count", 32'(hs), 32'(QDEPTH));
        chk("bubble_valid_low", 32'(imem_req_valid), 32'h0);
        buble_hold = 0;
        repeat (12) step();
        for (int i = 0; i < 6; i++) chk_dlv("bubble_no_loss", i, 32'(i * 4));

        // misprediction with two requests in flight
        do_reset("rst_mis");
        lat = 3;
        mis_arm = 1;
        for (int i = 0; i < 50 && !fired; i++) step();
        if (!fired) begin
            n_cmp++; n_bad++;
            $display("FAIL mis_fire: never reached two outstanding, got 0 expected 1");
        end else begin
            chk("mis_flush", 32'(inst_valid_o), 32'h0);
            repeat (20) step();
            chk_dlv("mis_first_pc", fire_idx, 32'h100);
        end
        mis_arm = 0;

        // early-decode jump on head PC 0x8
        do_reset("rst_jump");
        lat = 1;
        jump_arm = 1; jump_on = 32'h8; jump_tgt = 32'h40;
        repeat (20) step();
        jump_arm = 0;
        if (fired) begin
            chk_dlv("jump_src", fire_idx, 32'h8);
            chk_dlv("jump_next", fire_idx + 1, 32'h40);
        end else begin
            n_cmp++; n_bad++;
            $display("FAIL jump_fire: head 0x8 never reached, got 0 expected 1");
        end
        cnt = 0;
        foreach (dlv[i]) if (dlv[i] == 32'hC || dlv[i] == 32'h10) cnt++;
        chk("jump_skipped", 32'(cnt), 32'h0);

        // misprediction and jump together
        do_reset("rst_both");
        both_arm = 1; look_addr = 0; got_addr = 0;
        repeat (15) step();
        both_arm = 0;
        if (got_addr) chk("both_next_addr", first_addr, 32'h200);
        else begin
            n_cmp++; n_bad++;
            $display("FAIL both_next_addr: no request after redirect, expected 00000200");
        end
        chk_dlv("both_first_pc", fire_idx, 32'h200);
        look_addr = 0;

        // randomized traffic, then reset mid-stream
        do_reset("rst_rand");
        lat = 3; ready_rand = 1; rand_mode = 1;
        repeat (300) step();
        do_reset("rst_midstream");
        lat = 2;
        repeat (150) step();
        rand_mode = 0; ready_rand = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
